// File: rtl/dm_mem_arbiter.sv
// Two-requester round-robin arbiter sharing a single memory port.
// One transaction in flight; read responses are routed back to the owner.
module dm_mem_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned STROBE_WIDTH  = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [1:0]                i_req_valid,
    input  logic [1:0]                i_req_rd_wr,
    input  logic [2*ADDRESS_WIDTH-1:0] i_req_address,
    input  logic [2*DATA_WIDTH-1:0]    i_req_write_data,
    input  logic [2*STROBE_WIDTH-1:0]  i_req_write_strobe,
    output logic [1:0]                o_req_ready,
    output logic [DATA_WIDTH-1:0]     o_req_read_data,
    output logic [1:0]                o_req_read_valid,
    input  logic [1:0]                i_req_read_ready,
    output logic                      o_mem_valid,
    output logic                      o_mem_rd_wr,
    output logic [ADDRESS_WIDTH-1:0]  o_mem_address,
    input  logic                      i_mem_ready,
    output logic [DATA_WIDTH-1:0]     o_mem_write_data,
    output logic [STROBE_WIDTH-1:0]   o_mem_write_strobe,
    input  logic [DATA_WIDTH-1:0]     i_mem_read_data,
    input  logic                      i_mem_read_valid,
    output logic                      o_mem_read_ready,
    output logic                      o_grant,
    output logic                      o_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       last_grant;
    logic       winner;
    logic       capture;

    // Next-state, winner selection and combinational handshake outputs
    always_comb begin
        state_next       = state;
        winner           = ~last_grant;
        capture          = 1'b0;
        o_req_ready      = 2'b00;
        o_req_read_valid = 2'b00;
        o_req_read_data  = '0;
        o_mem_read_ready = 1'b0;

        if (i_req_valid == 2'b01) begin
            winner = 1'b0;
        end else if (i_req_valid == 2'b10) begin
            winner = 1'b1;
        end

        case (state)
            IDLE: begin
                if ((|i_req_valid) && !i_rst) begin
                    capture             = 1'b1;
                    o_req_ready[winner] = 1'b1;
                    state_next          = REQ;
                end
            end
            REQ: begin
                if (i_mem_ready) begin
                    state_next = o_mem_rd_wr ? RESP : IDLE;
                end
            end
            RESP: begin
                o_mem_read_ready             = i_req_read_ready[o_grant];
                o_req_read_valid[o_grant]    = i_mem_read_valid;
                o_req_read_data              = i_mem_read_data;
                if (i_mem_read_valid && i_req_read_ready[o_grant]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, grant history and latched request fields
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state              <= IDLE;
            last_grant         <= 1'b1;
            o_grant            <= 1'b0;
            o_mem_rd_wr        <= 1'b0;
            o_mem_address      <= '0;
            o_mem_write_data   <= '0;
            o_mem_write_strobe <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                last_grant         <= winner;
                o_grant            <= winner;
                o_mem_rd_wr        <= i_req_rd_wr[winner];
                o_mem_address      <= winner ? i_req_address[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                                             : i_req_address[ADDRESS_WIDTH-1:0];
                o_mem_write_data   <= winner ? i_req_write_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                             : i_req_write_data[DATA_WIDTH-1:0];
                o_mem_write_strobe <= winner ? i_req_write_strobe[2*STROBE_WIDTH-1:STROBE_WIDTH]
                                             : i_req_write_strobe[STROBE_WIDTH-1:0];
            end
        end
    end

    assign o_mem_valid = (state == REQ);
    assign o_busy      = (state != IDLE);

endmodule

// File: doc/dm_mem_arbiter.md
Name: dm_mem_arbiter

Overview:
- Two-requester arbiter sharing one memory port (o_mem_*/i_mem_* handshake) between two cache instances, e.g. I-side and D-side dm_cache.
- Captures one request at a time with round-robin priority and drives it to memory.
- For reads, routes the memory read response back to the winning requester.
- One transaction in flight; no reordering.

Parameters:
- ADDRESS_WIDTH, 32, address bits per request
- DATA_WIDTH, 32, read/write data bits
- STROBE_WIDTH, 4, byte-lane write strobes (DATA_WIDTH/8)

Ports:
- i_clk  in  1  clock, all logic rising-edge
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  2  request valid, bit n = requester n
- i_req_rd_wr  in  2  1=read, 0=write, per requester
- i_req_address  in  2*ADDRESS_WIDTH  packed, requester n at [n*AW +: AW]
- i_req_write_data  in  2*DATA_WIDTH  packed write data
- i_req_write_strobe  in  2*STROBE_WIDTH  packed strobes
- o_req_ready  out  2  one-cycle accept pulse to winner
- o_req_read_data  out  DATA_WIDTH  read data, shared by both requesters
- o_req_read_valid  out  2  read data valid, only the owning bit asserts
- i_req_read_ready  in  2  requester n can take read data
- o_mem_valid  out  1  memory request valid
- o_mem_rd_wr  out  1  latched rd_wr
- o_mem_address  out  ADDRESS_WIDTH  latched address
- i_mem_ready  in  1  memory accepts request
- o_mem_write_data  out  DATA_WIDTH  latched write data
- o_mem_write_strobe  out  STROBE_WIDTH  latched strobes
- i_mem_read_data  in  DATA_WIDTH  memory read data
- i_mem_read_valid  in  1  memory read data valid
- o_mem_read_ready  out  1  read data accepted
- o_grant  out  1  index of current/last owner
- o_busy  out  1  state != IDLE

Behaviour:
- i_clk is the only clock. i_rst is synchronous, active-high.
- On reset: state=IDLE, last_grant=1 (so requester 0 wins the first tie).
- Reset values: all outputs 0; latched request registers 0.
- Reset is honoured in any state; an in-flight memory transaction is abandoned, and memory is reset alongside.
- FSM IDLE:
  - If any i_req_valid, choose the winner w:
    - single requester wins outright;
    - if both are valid, w = ~last_grant.
  - Combinationally assert o_req_ready[w] this cycle.
  - Latch w's rd_wr/address/data/strobe.
  - Set last_grant=w and o_grant=w.
  - Go to REQ.
  - No request: stay IDLE.
- FSM REQ:
  - o_mem_valid=1 with latched fields, held stable until i_mem_ready=1.
  - On valid&ready: write -> IDLE; read -> RESP.
  - Latency: request visible on memory one cycle after requester accept.
- FSM RESP:
  - o_mem_read_ready = i_req_read_ready[owner].
  - o_req_read_valid[owner] = i_mem_read_valid; other bit 0.
  - o_req_read_data = i_mem_read_data (pass-through, zero latency).
  - On i_mem_read_valid & o_mem_read_ready -> IDLE.
- o_req_ready is 0 outside IDLE; requesters hold valid and fields until accepted.
- A requester withdrawing valid before accept is legal; no capture occurs.
- Back-to-back: IDLE->REQ->IDLE takes a minimum of 2 cycles per write when memory is ready immediately. A new request is captured in the cycle after write completion.
- Fairness: with both valid continuously, grants alternate 0,1,0,1 regardless of read/write mix.
- i_mem_read_valid outside RESP is ignored; o_mem_read_ready=0 there.
- o_busy=1 in REQ and RESP.

Test Plan:
- Reset, then only requester 0 writes addr 0x100, data 0xDEADBEEF, strobe 0xF, i_mem_ready=1 -> o_req_ready[0] pulse at cycle T, then o_mem_valid at T+1 with those fields, o_busy=0 at T+2.
- Both valid writes held for 4 transactions -> grant order 0,1,0,1; each o_mem_address matches the granted requester.
- Requester 1 reads 0x40, i_mem_ready low 3 cycles -> o_mem_valid/address stable for 4 cycles. Then read data 0x12345678 -> o_req_read_valid=2'b10, data 0x12345678, bit 0 never set.
- RESP with i_req_read_ready[1]=0 for 2 cycles while i_mem_read_valid=1 -> o_mem_read_ready=0, stays RESP; completes the cycle ready rises.
- Assert i_rst mid-REQ -> next cycle all outputs 0, state IDLE; a subsequent simultaneous request grants requester 0.
